mips_mem_responder: RTL and testbench
=====================================

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words stored.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, legal range 0..15, meaning the wait states inserted before every response.
REQ-003 The block SHALL have parameter PROTECT_TOP, default 64, meaning that word addresses below this value form the instruction region.
REQ-004 Port clk1, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port req, input, 1 bit: request valid from the initiator.
REQ-007 Port we, input, 1 bit: 1 = store (SW), 0 = load (LW).
REQ-008 Port addr, input, 11 bits: word address; this equals EX_MEM_ALUOut[10:0] of the pipeline.
REQ-009 Port wdata, input, 32 bits: store data.
REQ-010 Port rdata, output, 32 bits: load data.
REQ-011 Port ack, output, 1 bit: response strobe, one cycle wide.
REQ-012 Port err, output, 1 bit: error flag, qualified by ack.
REQ-013 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015 In IDLE with req=1, the block SHALL capture we, addr and wdata, load the wait counter with WAIT_CYCLES, and go to WAIT. Inputs SHALL be ignored outside IDLE.
REQ-016 In WAIT, the block SHALL go to RESP if the counter is 0; otherwise it SHALL decrement the counter and stay in WAIT.
REQ-017 On the WAIT->RESP edge, the block SHALL perform the access:
- store: write the captured wdata to the captured address;
- load: load rdata from the captured address.
REQ-018 ack SHALL be high only while in RESP; RESP SHALL always return to IDLE on the next edge.
REQ-019 Latency: with the accept edge numbered E0, ack SHALL be high between E(WAIT_CYCLES+1) and E(WAIT_CYCLES+2).
REQ-020 rdata SHALL hold its value until the next successful load; stores and errored accesses SHALL leave rdata unchanged.
REQ-021 A captured address >= DEPTH SHALL cause no memory access and SHALL raise err=1 together with ack.
REQ-022 err SHALL be 0 whenever ack=0.
REQ-023 If req is still high in the IDLE cycle after ack, the block SHALL treat it as a new request. The minimum request spacing is therefore WAIT_CYCLES+3 cycles.
REQ-024 A load and a store to the same address issued back-to-back SHALL be strictly ordered: a load after a store SHALL return the stored value.
REQ-025 Memory contents SHALL be writable hierarchically by the bench (preload) while the block is idle.

Reset
REQ-026 On rst, the block SHALL force: state=IDLE, counter=0, ack=0, err=0, busy=0, rdata=0.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 A reset asserted mid-operation (in WAIT) SHALL abort the access: no write, no ack.

Configuration
REQ-029 Macro MIPS_MEM_PROTECT_EN SHALL control instruction-region write protection.
REQ-030 With MIPS_MEM_PROTECT_EN defined, a store whose address < PROTECT_TOP SHALL NOT modify memory and SHALL respond with ack=1 and err=1; loads in that region SHALL be unaffected.
REQ-031 Without MIPS_MEM_PROTECT_EN, all in-range addresses SHALL be writable and PROTECT_TOP SHALL be unused.

Structure
REQ-032 Shared package mips_mem_pkg SHALL hold:
- the FSM state encoding (IDLE/WAIT/RESP);
- default DEPTH, WAIT_CYCLES and PROTECT_TOP constants;
- opcode constants LW=6'b001000 and SW=6'b001001, for bench decoding.
REQ-033 The storage array SHALL be one sub-module, mips_mem_array, with synchronous write and registered read, DEPTH x 32.
REQ-034 The FSM, counter and error/protect logic SHALL live in mips_mem_responder.

Verification
REQ-035 WAIT_CYCLES=2: store 85 to address 120, then load 120 -> rdata=85, err=0; ack at E3 after each accept edge.
REQ-036 WAIT_CYCLES=0 and WAIT_CYCLES=15: single load -> ack exactly one cycle wide at E1 and E16 respectively; busy high from E1 to ack.
REQ-037 Load from address 1500 with DEPTH=1024 -> ack=1, err=1, rdata unchanged from its prior value.
REQ-038 Store 130 to address 121, with rst pulsed during WAIT -> no ack; a subsequent load of 121 returns its preloaded value.
REQ-039 MIPS_MEM_PROTECT_EN defined: store 0xDEADBEEF to address 5 -> err=1, Mem[5] unchanged; store to address 64 -> err=0, written. Without the macro, the address-5 store succeeds.
REQ-040 req held high continuously for 3 loads of addresses 120, 121, 122 -> three acks spaced WAIT_CYCLES+3 cycles apart, returning the preloaded values in order.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder.
//   - FSM state encoding (IDLE / WAIT / RESP)
//   - default geometry and timing constants
//   - LW / SW opcodes, used when decoding instruction streams in benches
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_DEPTH       = 1024;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
    localparam int unsigned DEFAULT_PROTECT_TOP = 64;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [5:0] LW = 6'b001000;
    localparam logic [5:0] SW = 6'b001001;

endpackage

// File: rtl/mips_mem_array.sv
// DEPTH x 32 storage for the MIPS data-memory responder.
// Synchronous write, registered read. The read register only updates on a
// read strobe so it holds the last loaded word between loads.
// Ports:
//   clk1  - clock
//   rst   - async active-high reset (clears the read register only)
//   we    - write strobe
//   re    - read strobe
//   addr  - word address
//   wdata - write data
//   rdata - registered read data
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [MEM_AW-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // Contents survive reset; the bench may preload this array while idle.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk1) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Wait-state memory responder for a MIPS pipeline data port.
// A request accepted in IDLE is held for WAIT_CYCLES wait states, then the
// access is performed and acknowledged for exactly one cycle.
// Ports:
//   clk1  - clock (all state changes on rising edge)
//   rst   - async active-high reset
//   req   - request valid, sampled only in IDLE
//   we    - 1 = store, 0 = load
//   addr  - word address (EX_MEM_ALUOut[10:0])
//   wdata - store data
//   rdata - load data, held until the next successful load
//   ack   - one-cycle response strobe
//   err   - error flag, qualified by ack
//   busy  - high whenever not in IDLE
// Optional feature: define MIPS_MEM_PROTECT_EN to make stores below
// PROTECT_TOP fail with err=1 (instruction-region write protection).
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = DEFAULT_DEPTH,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int unsigned PROTECT_TOP = DEFAULT_PROTECT_TOP
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                err_q, err_next;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                accept;
    logic                access;
    logic                in_range;
    logic                protect_hit;
    logic                mem_we;
    logic                mem_re;

    assign in_range = ({{(32-ADDR_W){1'b0}}, addr_q} < DEPTH);

`ifdef MIPS_MEM_PROTECT_EN
    assign protect_hit = we_q && ({{(32-ADDR_W){1'b0}}, addr_q} < PROTECT_TOP);
`else
    assign protect_hit = 1'b0;
    logic unused_protect_top;
    assign unused_protect_top = (PROTECT_TOP != 0);
`endif

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            err_q <= err_next;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_next   = err_q;
        accept     = 1'b0;
        access     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                    cnt_next   = CNT_W'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    // The access happens on this edge so rdata is valid with ack.
                    access     = 1'b1;
                    state_next = RESP;
                    err_next   = !in_range || protect_hit;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_we = access && we_q && in_range && !protect_hit;
    assign mem_re = access && !we_q && in_range;

    assign ack  = (state == RESP);
    assign err  = ack && err_q;
    assign busy = (state != IDLE);

    mips_mem_array #(
        .DEPTH  (DEPTH),
        .MEM_AW (MEM_AW)
    ) u_array (
        .clk1  (clk1),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_q[MEM_AW-1:0]),
        .wdata (wdata_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder. A reference model (plain arrays)
// computes each response when a request is issued and queues it; a monitor
// pops and compares whenever ack is seen. Two extra instances with
// WAIT_CYCLES=0 and 15 check latency and busy timing.
module tb_mips_mem_responder;

    localparam int unsigned MW  = 2;
    localparam int unsigned DEP = 1024;

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk1 = 1'b0;
    logic        rst  = 1'b1;
    logic        req  = 1'b0;
    logic        we   = 1'b0;
    logic [10:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack, err, busy;

    logic        req_a = 1'b0;
    logic [31:0] rdata_unused0, rdata_unused15;
    logic        ack0, err0, busy0, ack15, err15, busy15;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    logic [31:0] model_mem [DEP];
    logic [31:0] model_rd = '0;
    exp_t        sb [$];
    exp_t        mon_e;

    mips_mem_responder #(.DEPTH(DEP), .WAIT_CYCLES(MW), .PROTECT_TOP(64)) dut (
        .clk1 (clk1), .rst (rst), .req (req), .we (we), .addr (addr), .wdata (wdata),
        .rdata (rdata), .ack (ack), .err (err), .busy (busy)
    );

    mips_mem_responder #(.DEPTH(DEP), .WAIT_CYCLES(0), .PROTECT_TOP(64)) dut_w0 (
        .clk1 (clk1), .rst (rst), .req (req_a), .we (1'b0), .addr (11'd3), .wdata (32'd0),
        .rdata (rdata_unused0), .ack (ack0), .err (err0), .busy (busy0)
    );

    mips_mem_responder #(.DEPTH(DEP), .WAIT_CYCLES(15), .PROTECT_TOP(64)) dut_w15 (
        .clk1 (clk1), .rst (rst), .req (req_a), .we (1'b0), .addr (11'd3), .wdata (32'd0),
        .rdata (rdata_unused15), .ack (ack15), .err (err15), .busy (busy15)
    );

    initial forever #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required completion in time");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, required 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: decide the response from the addressing rules alone.
    function automatic void push_expected(input logic w, input logic [10:0] a,
                                          input logic [31:0] d, input int unsigned acc_cyc);
        exp_t e;
        logic prot;
        prot = 1'b0;
`ifdef MIPS_MEM_PROTECT_EN
        prot = w && (a < 11'd64);
`endif
        e.err = (a >= 11'd1024) || prot;
        if (!e.err) begin
            if (w) model_mem[a[9:0]] = d;
            else   model_rd = model_mem[a[9:0]];
        end
        e.rdata = model_rd;
        e.cyc   = acc_cyc + MW + 1;
        sb.push_back(e);
    endfunction

    // Monitor: every ack consumes one expected response.
    always @(negedge clk1) begin
        if (!rst) begin
            if (ack) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got ack=1 at cycle %0d, required no response",
                             cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_cycle", cyc, mon_e.cyc);
                    check("err", {31'b0, err}, {31'b0, mon_e.err});
                    check("rdata", rdata, mon_e.rdata);
                end
            end else begin
                check("err_without_ack", {31'b0, err}, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk1);
        while (busy && n < 100) begin
            @(negedge clk1);
            n++;
        end
        check("wait_idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic issue(input logic w, input logic [10:0] a, input logic [31:0] d);
        wait_idle();
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk1); #1;
        req = 1'b0;
        push_expected(w, a, d, cyc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk1);
            n++;
        end
        check("drain_pending", sb.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int unsigned a0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            model_mem[i] = v;
            dut.u_array.mem[i] <= v;
        end

        // Reset state.
        #2;
        check("reset_rdata", rdata, 32'd0);
        check("reset_ack", {31'b0, ack}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk1);
        rst = 1'b0;

        // Store then load at address 120.
        issue(1'b1, 11'd120, 32'd85);
        issue(1'b0, 11'd120, 32'd0);

        // Out-of-range load: error, rdata unchanged.
        issue(1'b0, 11'd1500, 32'd0);

        // Instruction-region protection (or plain writes without it).
        issue(1'b1, 11'd5, 32'hDEADBEEF);
        issue(1'b0, 11'd5, 32'd0);
        issue(1'b1, 11'd64, 32'h1234_5678);
        issue(1'b0, 11'd64, 32'd0);

        // Reset during WAIT aborts the store to 121.
        wait_idle();
        drain();
        req = 1'b1; we = 1'b1; addr = 11'd121; wdata = 32'd130;
        @(posedge clk1); #1;
        req = 1'b0;
        @(posedge clk1); #1;
        rst = 1'b1;
        model_rd = '0;
        #2;
        check("abort_rdata", rdata, 32'd0);
        check("abort_ack", {31'b0, ack}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        @(negedge clk1);
        rst = 1'b0;
        issue(1'b0, 11'd121, 32'd0);

        // req held high across three loads: accepts spaced MW+3 cycles.
        wait_idle();
        req = 1'b1; we = 1'b0; addr = 11'd120;
        a0 = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk1); #1;
            if (i == 0) a0 = cyc;
            push_expected(1'b0, 11'(120 + i), 32'd0, a0 + i * (MW + 3));
            addr = 11'(121 + i);
            if (i < 2) repeat (MW + 2) @(posedge clk1);
        end
        req = 1'b0;
        drain();

        // Latency of the WAIT_CYCLES=0 and 15 instances.
        check("aux_idle_w0", {31'b0, busy0}, 32'd0);
        check("aux_idle_w15", {31'b0, busy15}, 32'd0);
        @(negedge clk1);
        req_a = 1'b1;
        @(posedge clk1); #1;
        req_a = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            check("w0_ack", {31'b0, ack0}, {31'b0, k == 1});
            check("w0_busy", {31'b0, busy0}, {31'b0, k <= 1});
            check("w0_err", {31'b0, err0}, 32'd0);
            check("w15_ack", {31'b0, ack15}, {31'b0, k == 16});
            check("w15_busy", {31'b0, busy15}, {31'b0, k <= 16});
            check("w15_err", {31'b0, err15}, 32'd0);
            @(posedge clk1); #1;
        end

        // Randomised traffic.
        for (int n = 0; n < 200; n++) begin
            logic        w;
            logic [10:0] a;
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) a = 11'(1024 + $urandom_range(0, 1023));
            else                           a = 11'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) @(negedge clk1);
            issue(w, a, $urandom);
        end

        wait_idle();
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
